// File: rtl/cnt_mod_pkg.sv
// Shared types and step function for the parametrised modulo counter.
// next_cnt works in 33 bits so any WIDTH up to 32 can step without overflow.
package cnt_mod_pkg;

    typedef enum logic [1:0] {CNT_WRAP, CNT_SAT, CNT_ONESHOT} mode_t;
    typedef enum logic {RUN, HALT} state_t;

    localparam int unsigned CNT_AW = 33;

    typedef struct packed {
        logic [CNT_AW-1:0] val;
        logic              bnd;
    } step_t;

    // One enabled step from cur; bnd flags an attempt to step past 0 or max.
    function automatic step_t next_cnt(input logic [CNT_AW-1:0] cur,
                                       input logic              dir,
                                       input logic [CNT_AW-1:0] max,
                                       input mode_t             mode);
        step_t r;
        r.val = cur;
        r.bnd = 1'b0;
        if (dir) begin
            if (cur < max) begin
                r.val = cur + 33'd1;
            end else begin
                r.bnd = 1'b1;
                if (mode == CNT_WRAP) r.val = '0;
            end
        end else begin
            if (cur != '0) begin
                r.val = cur - 33'd1;
            end else begin
                r.bnd = 1'b1;
                if (mode == CNT_WRAP) r.val = max;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cnt_mod.sv
// Parametrised up/down modulo counter with wrap, saturate and one-shot
// boundary modes, registered boundary pulse and halted flag.
module cnt_mod
    import cnt_mod_pkg::*;
#(
    parameter int unsigned       WIDTH   = 8,
    parameter logic [CNT_AW-1:0] MOD_MAX = (33'd1 << WIDTH) - 33'd1,
    parameter mode_t             MODE    = CNT_WRAP,
    parameter logic [CNT_AW-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] ld_val,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             halted
);

    localparam logic [CNT_AW-1:0] FULL_MAX = (33'd1 << WIDTH) - 33'd1;

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("cnt_mod: WIDTH must be in 2..32");
    end
    if (MOD_MAX < 33'd1 || MOD_MAX > FULL_MAX) begin : g_bad_max
        $error("cnt_mod: MOD_MAX must be in 1..2**WIDTH-1");
    end
    if (RST_VAL > MOD_MAX) begin : g_bad_rst
        $error("cnt_mod: RST_VAL must not exceed MOD_MAX");
    end

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    state_t           state_q, state_d;

    logic [CNT_AW-1:0] cur_w;
    step_t             step_w;
    logic              step_act_w;
    logic              unused_w;

    assign cur_w      = CNT_AW'(cnt_q);
    assign step_w     = next_cnt(cur_w, dir, MOD_MAX, MODE);
    assign step_act_w = en && (state_q == RUN) && !clr && !load;
    assign unused_w   = ^step_w.val[CNT_AW-1:WIDTH];

    // clr beats load beats a step; rst is handled in the register itself.
    always_comb begin
        cnt_d   = cnt_q;
        tc_d    = 1'b0;
        state_d = state_q;
        if (clr) begin
            cnt_d   = RST_VAL[WIDTH-1:0];
            state_d = RUN;
        end else if (load) begin
            cnt_d   = (CNT_AW'(ld_val) > MOD_MAX) ? MOD_MAX[WIDTH-1:0] : ld_val;
            state_d = RUN;
        end else if (step_act_w) begin
            cnt_d = step_w.val[WIDTH-1:0];
            tc_d  = step_w.bnd;
            if (step_w.bnd && MODE == CNT_ONESHOT) state_d = HALT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= RST_VAL[WIDTH-1:0];
            tc_q    <= 1'b0;
            state_q <= RUN;
        end else begin
            cnt_q   <= cnt_d;
            tc_q    <= tc_d;
            state_q <= state_d;
        end
    end

    assign cnt    = cnt_q;
    assign tc     = tc_q;
    assign halted = (state_q == HALT);

`ifdef ASSERTS_SV
    a_range: assert property (@(posedge clk) disable iff (rst)
        CNT_AW'(cnt_q) <= MOD_MAX);
    a_known: assert property (@(posedge clk) disable iff (rst)
        !$isunknown({cnt_q, tc_q, state_q}));
    a_up: assert property (@(posedge clk) disable iff (rst)
        (step_act_w && dir && !step_w.bnd) |=> cnt_q == $past(cnt_q) + WIDTH'(1));
    a_hold: assert property (@(posedge clk) disable iff (rst)
        (state_q == HALT && !clr && !load) |=> $stable(cnt_q));
    a_tc: assert property (@(posedge clk) disable iff (rst)
        tc_q |-> $past(step_act_w && step_w.bnd));
`endif

endmodule

// File: tb/tb_cnt_mod.sv
// Directed bench for cnt_mod: five configurations share one stimulus bus,
// each table vector names the instance whose outputs it checks.
module tb_cnt_mod;
    import cnt_mod_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0, dir = 1'b1, clr = 1'b0, load = 1'b0;
    logic [7:0] ld_val = '0;

    logic [7:0] cnt_a, cnt_e;
    logic [3:0] cnt_b, cnt_c, cnt_d;
    logic       tc_a, tc_b, tc_c, tc_d, tc_e;
    logic       h_a, h_b, h_c, h_d, h_e;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cnt_mod #(.WIDTH(8)) u_a (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr), .load(load),
        .ld_val(ld_val), .cnt(cnt_a), .tc(tc_a), .halted(h_a));
    cnt_mod #(.WIDTH(4), .MOD_MAX(33'd9), .MODE(CNT_WRAP)) u_b (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr), .load(load),
        .ld_val(ld_val[3:0]), .cnt(cnt_b), .tc(tc_b), .halted(h_b));
    cnt_mod #(.WIDTH(4), .MOD_MAX(33'd9), .MODE(CNT_SAT)) u_c (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr), .load(load),
        .ld_val(ld_val[3:0]), .cnt(cnt_c), .tc(tc_c), .halted(h_c));
    cnt_mod #(.WIDTH(4), .MOD_MAX(33'd5), .MODE(CNT_ONESHOT)) u_d (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr), .load(load),
        .ld_val(ld_val[3:0]), .cnt(cnt_d), .tc(tc_d), .halted(h_d));
    cnt_mod #(.WIDTH(8), .MOD_MAX(33'd99), .MODE(CNT_WRAP), .RST_VAL(33'd3)) u_e (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr), .load(load),
        .ld_val(ld_val), .cnt(cnt_e), .tc(tc_e), .halted(h_e));

    typedef struct {
        int         sel;
        logic       rst, clr, load, en, dir;
        logic [7:0] ld;
        logic [7:0] c;
        logic       t, h;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [9:0] obs(input int sel);
        case (sel)
            0:       return {cnt_a, tc_a, h_a};
            1:       return {4'd0, cnt_b, tc_b, h_b};
            2:       return {4'd0, cnt_c, tc_c, h_c};
            3:       return {4'd0, cnt_d, tc_d, h_d};
            default: return {cnt_e, tc_e, h_e};
        endcase
    endfunction

    task automatic add(input int sel, input logic r, input logic c_, input logic l,
                       input logic e, input logic d, input int ld,
                       input int c, input logic t, input logic h);
        vec_t v;
        v.sel = sel; v.rst = r; v.clr = c_; v.load = l; v.en = e; v.dir = d;
        v.ld = 8'(ld); v.c = 8'(c); v.t = t; v.h = h;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic c_, input logic l,
                         input logic e, input logic d, input logic [7:0] ld);
        rst = r; clr = c_; load = l; en = e; dir = d; ld_val = ld;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [9:0] o;

        // reset state of every configuration
        for (int s = 0; s < 5; s++) add(s, 1,0,0,0,1, 0, (s == 4) ? 3 : 0, 0, 0);

        // WRAP mod 9 counting down from 2
        add(1, 0,0,1,0,0, 2, 2,0,0);
        add(1, 0,0,0,1,0, 0, 1,0,0);
        add(1, 0,0,0,1,0, 0, 0,0,0);
        add(1, 0,0,0,1,0, 0, 9,1,0);
        add(1, 0,0,0,1,0, 0, 8,0,0);

        // SAT mod 9 counting up from 7
        add(2, 0,0,1,0,1, 7, 7,0,0);
        add(2, 0,0,0,1,1, 0, 8,0,0);
        add(2, 0,0,0,1,1, 0, 9,0,0);
        add(2, 0,0,0,1,1, 0, 9,1,0);
        add(2, 0,0,0,1,1, 0, 9,1,0);
        add(2, 0,0,0,1,1, 0, 9,1,0);
        add(2, 0,0,0,0,1, 0, 9,0,0);

        // ONESHOT mod 5: halt at the top, ignore en, resume on load
        add(3, 1,0,0,0,1, 0, 0,0,0);
        for (int i = 1; i <= 5; i++) add(3, 0,0,0,1,1, 0, i,0,0);
        add(3, 0,0,0,1,1, 0, 5,1,1);
        for (int i = 0; i < 10; i++) add(3, 0,0,0,1,1, 0, 5,0,1);
        add(3, 0,0,1,1,1, 2, 2,0,0);
        add(3, 0,0,0,1,1, 0, 3,0,0);

        // priority rst > clr > load > en, clamped load, wrap both ways at 99
        add(4, 1,0,0,0,1, 0, 3,0,0);
        add(4, 0,0,0,1,1, 0, 4,0,0);
        add(4, 0,0,0,1,1, 0, 5,0,0);
        add(4, 1,1,1,1,1, 7, 3,0,0);
        add(4, 0,1,1,1,1, 7, 3,0,0);
        add(4, 0,0,1,1,1, 200, 99,0,0);
        add(4, 0,0,0,1,1, 0, 0,1,0);
        add(4, 0,0,0,1,1, 0, 1,0,0);
        add(4, 0,0,0,1,0, 0, 0,0,0);
        add(4, 0,0,0,1,0, 0, 99,1,0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].clr, vecs[i].load, vecs[i].en,
                  vecs[i].dir, vecs[i].ld);
            tick();
            o = obs(vecs[i].sel);
            chk("vec_cnt", i, o[9:2], vecs[i].c);
            chk("vec_tc", i, {7'd0, o[1]}, {7'd0, vecs[i].t});
            chk("vec_halted", i, {7'd0, o[0]}, {7'd0, vecs[i].h});
        end

        // 8-bit natural overflow: 260 steps from reset
        drive(1,0,0,0,1, 8'd0);
        tick();
        chk("a_rst_cnt", 0, cnt_a, 8'd0);
        drive(0,0,0,1,1, 8'd0);
        for (int i = 1; i <= 260; i++) begin
            tick();
            chk("a_run_cnt", i, cnt_a, 8'(i % 256));
            chk("a_run_tc", i, {7'd0, tc_a}, (i == 256) ? 8'd1 : 8'd0);
        end

        // reset while counting at 0x42
        drive(1,0,0,0,1, 8'd0);
        tick();
        drive(0,0,0,1,1, 8'd0);
        for (int i = 0; i < 66; i++) tick();
        chk("a_mid_cnt", 0, cnt_a, 8'h42);
        drive(1,0,0,1,1, 8'd0);
        tick();
        chk("a_mid_rst_cnt", 0, cnt_a, 8'd0);
        chk("a_mid_rst_tc", 0, {7'd0, tc_a}, 8'd0);
        drive(0,0,0,1,1, 8'd0);
        tick();
        chk("a_restart_cnt", 0, cnt_a, 8'd1);
        chk("a_restart_halted", 0, {7'd0, h_a}, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
